// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shadow scoreboard entry type and forward-select encoding
package pipe_hazard_ctrl_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } hz_entry_t;
  localparam int FWD_RF = 0;
  function automatic int fwd_of_stage(input int k);
    return k + 1;
  endfunction
endpackage

// File: rtl/hz_fwd_pick.sv
// hz_fwd_pick: youngest-producer search for one source operand
module hz_fwd_pick
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 2,
  localparam int FW        = $clog2(DEPTH + 1)
) (
  input  hz_entry_t [DEPTH-1:0] ents,
  input  logic [4:0]            rs,
  input  logic                  use_rs,
  output logic [FW-1:0]         fwd,
  output logic                  need_stall
);
  logic rdy;
  always_comb begin
    fwd = FW'(FWD_RF);
    need_stall = 1'b0;
    rdy = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (use_rs && rs != 5'd0 && ents[k].valid && ents[k].wr && ents[k].rd == rs) begin
        rdy = k >= (ents[k].is_load ? LOAD_READY : ALU_READY);
        fwd = rdy ? FW'(fwd_of_stage(k)) : FW'(FWD_RF);
        need_stall = !rdy;
      end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: shadow-scoreboard hazard, forwarding and pipeline control unit
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 2,
  parameter int BR_STAGE   = 1,
  parameter int CNT_W      = 32,
  localparam int FW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             redirect,
  output logic [FW-1:0]    fwd_rs1,
  output logic [FW-1:0]    fwd_rs2,
  output logic             stall_id,
  output logic [DEPTH+1:0] flush,
  output logic             freeze,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);
  localparam logic [DEPTH+1:0] FLUSH_MASK = (DEPTH + 2)'((1 << (BR_STAGE + 2)) - 1);
  hz_entry_t [DEPTH-1:0] stg;
  hz_entry_t             id_ent;
  logic [FW-1:0]         f1, f2;
  logic                  ns1, ns2, go_rdr;
  hz_fwd_pick #(.DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)) u_pick1 (
    .ents(stg), .rs(id_rs1), .use_rs(id_use_rs1), .fwd(f1), .need_stall(ns1)
  );
  hz_fwd_pick #(.DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)) u_pick2 (
    .ents(stg), .rs(id_rs2), .use_rs(id_use_rs2), .fwd(f2), .need_stall(ns2)
  );
  assign freeze   = imem_stall | dmem_stall;
  assign go_rdr   = redirect & ~freeze;
  assign stall_id = id_valid & ~freeze & ~go_rdr & (ns1 | ns2);
  assign fwd_rs1  = go_rdr ? '0 : f1;
  assign fwd_rs2  = go_rdr ? '0 : f2;
  assign flush    = go_rdr ? FLUSH_MASK : '0;
  assign id_ent   = '{valid: 1'b1, rd: id_rd, wr: id_wr && id_rd != 5'd0, is_load: id_is_load};
  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < DEPTH; k++) stage_valid[k] = stg[k].valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stg        <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (!freeze) begin
        stg[0] <= (id_valid && !stall_id && !go_rdr) ? id_ent : '0;
        for (int k = 1; k < DEPTH; k++) stg[k] <= (go_rdr && k <= BR_STAGE) ? '0 : stg[k-1];
      end
      if (stall_id && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (go_rdr && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (freeze && freeze_cnt != '1) freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end
endmodule
